// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, ALU operation and writeback enums,
// and the packed control word carried from decode to execute.
package rv32i_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        wb_sel_e    wb_sel;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
        logic [2:0] funct3;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // alt selects SUB/SRA; the caller masks it for OP-IMM where only SRAI uses it.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two async read ports with same-cycle writeback
// bypass, one write port, x0 hardwired to zero.
module regfile_2r1w (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0][4:0]  raddr,
    output logic [1:0][31:0] rdata,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [31:0]      wdata
);
    logic [31:0][31:0] regs;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rdata[p] = (raddr[p] == 5'd0)              ? 32'd0 :
                          (we && waddr == raddr[p])       ? wdata :
                                                            regs[raddr[p]];
    end
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID and ID/EX registers, register file, immediate
// generation, control decode and load-use hazard detection.
module id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   pc_if,
    input  logic [31:0]                   instr_if,
    input  logic                          flush,
    input  logic                          wb_we,
    input  logic [4:0]                    wb_rd,
    input  logic [31:0]                   wb_data,
    output logic                          stall,
    output logic                          idex_valid,
    output logic [31:0]                   idex_pc,
    output logic [31:0]                   idex_rs1_data,
    output logic [31:0]                   idex_rs2_data,
    output logic [31:0]                   idex_imm,
    output logic [4:0]                    idex_rs1,
    output logic [4:0]                    idex_rs2,
    output logic [4:0]                    idex_rd,
    output logic [rv32i_pkg::CTRL_W-1:0]  idex_ctrl
);
    import rv32i_pkg::*;

    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr;
    ctrl_t       idex_c, dec_ctrl;
    logic [31:0] dec_imm;
    logic        rs1_used, rs2_used;

    wire  [6:0]  opcode = ifid_instr[6:0];
    wire  [4:0]  rd     = ifid_instr[11:7];
    wire  [2:0]  f3     = ifid_instr[14:12];
    wire  [4:0]  rs1    = ifid_instr[19:15];
    wire  [4:0]  rs2    = ifid_instr[24:20];
    wire         b30    = ifid_instr[30];

    logic [1:0][31:0] rf_rdata;

    regfile_2r1w u_rf (
        .clk   (clk),
        .rst   (rst),
        .raddr ({rs2, rs1}),
        .rdata (rf_rdata),
        .we    (wb_we),
        .waddr (wb_rd),
        .wdata (wb_data)
    );

    wire [31:0] imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    wire [31:0] imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    wire [31:0] imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                         ifid_instr[30:25], ifid_instr[11:8], 1'b0};
    wire [31:0] imm_u = {ifid_instr[31:12], 12'b0};
    wire [31:0] imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                         ifid_instr[20], ifid_instr[30:21], 1'b0};

    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_ctrl.alu_op = ALU_PASS_B; dec_ctrl.alu_src_imm = 1'b1;
                dec_ctrl.reg_write = 1'b1; dec_imm = imm_u; rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                dec_ctrl.alu_src_pc = 1'b1; dec_ctrl.alu_src_imm = 1'b1;
                dec_ctrl.reg_write = 1'b1; dec_imm = imm_u; rs1_used = 1'b0;
            end
            OPC_JAL: begin
                dec_ctrl.alu_src_pc = 1'b1; dec_ctrl.alu_src_imm = 1'b1;
                dec_ctrl.reg_write = 1'b1; dec_ctrl.wb_sel = WB_PC4;
                dec_ctrl.jump = 1'b1; dec_imm = imm_j; rs1_used = 1'b0;
            end
            OPC_JALR: begin
                dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1;
                dec_ctrl.wb_sel = WB_PC4; dec_ctrl.jump = 1'b1; dec_ctrl.jalr = 1'b1;
                dec_ctrl.funct3 = f3; dec_imm = imm_i;
            end
            OPC_BRANCH: begin
                dec_ctrl.alu_op = ALU_SUB; dec_ctrl.branch = 1'b1;
                dec_ctrl.funct3 = f3; dec_imm = imm_b; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.mem_read = 1'b1;
                dec_ctrl.reg_write = 1'b1; dec_ctrl.wb_sel = WB_MEM;
                dec_ctrl.funct3 = f3; dec_imm = imm_i;
            end
            OPC_STORE: begin
                dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.mem_write = 1'b1;
                dec_ctrl.funct3 = f3; dec_imm = imm_s; rs2_used = 1'b1;
            end
            OPC_OPIMM: begin
                // instr[30] is immediate data except for SRAI
                dec_ctrl.alu_op = alu_from_f3(f3, (f3 == 3'b101) && b30);
                dec_ctrl.alu_src_imm = 1'b1; dec_ctrl.reg_write = 1'b1;
                dec_ctrl.funct3 = f3; dec_imm = imm_i;
            end
            OPC_OP: begin
                dec_ctrl.alu_op = alu_from_f3(f3, b30); dec_ctrl.reg_write = 1'b1;
                dec_ctrl.funct3 = f3; rs2_used = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    assign stall = !flush && ifid_valid && idex_valid && idex_c.mem_read && (idex_rd != 5'd0)
                && ((rs1_used && rs1 == idex_rd) || (rs2_used && rs2 == idex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= RESET_PC;
            ifid_instr <= NOP_INSTR;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= RESET_PC;
            ifid_instr <= NOP_INSTR;
        end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc_if;
            ifid_instr <= instr_if;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid    <= 1'b0;
            idex_pc       <= RESET_PC;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_c        <= '0;
        end else begin
            idex_rs1_data <= rf_rdata[0];
            idex_rs2_data <= rf_rdata[1];
            idex_imm      <= dec_imm;
            idex_rs1      <= rs1;
            idex_rs2      <= rs2;
            if (flush || stall) begin
                idex_valid <= 1'b0;
                idex_pc    <= RESET_PC;
                idex_rd    <= '0;
                idex_c     <= '0;
            end else begin
                idex_valid <= ifid_valid;
                idex_pc    <= ifid_pc;
                idex_rd    <= rd;
                idex_c     <= ifid_valid ? dec_ctrl : '0;
            end
        end
    end

    assign idex_ctrl = idex_c;
endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a cycle-level
// behavioural model of the decode pipeline and register file.
module tb_id_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, wb_we;
    logic [31:0] pc_if, instr_if, wb_data;
    logic [4:0]  wb_rd;
    logic        stall, idex_valid;
    logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [CTRL_W-1:0] idex_ctrl;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .instr_if(instr_if), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
        .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_ctrl(idex_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic        known, rs1u, rs2u, mr, mw, rw, br, jp, jr, ill;
        logic [1:0]  wb;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, rs1d, rs2d;
        logic [4:0]  rs1, rs2, rd;
        dec_t        d;
    } ex_t;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] rf [32];
    logic        m_ifv;
    logic [31:0] m_ifpc, m_ifins;
    ex_t         m_ex;
    logic        last_stall;
    ctrl_t       c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        return v[n-1] ? v - (32'd1 << n) : v;
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d = '0;
        d.rs1u = 1'b1; d.known = 1'b1;
        case (i[6:0])
            7'h37, 7'h17: begin d.imm = i & 32'hFFFF_F000; d.rs1u = 0; d.rw = 1; end
            7'h6F: begin
                d.imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
                d.rs1u = 0; d.rw = 1; d.jp = 1; d.wb = 2;
            end
            7'h67: begin d.imm = sext(i >> 20, 12); d.rw = 1; d.jp = 1; d.jr = 1; d.wb = 2; end
            7'h63: begin
                d.imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
                d.br = 1; d.rs2u = 1;
            end
            7'h03: begin d.imm = sext(i >> 20, 12); d.mr = 1; d.rw = 1; d.wb = 1; end
            7'h23: begin d.imm = sext({i[31:25], i[11:7]}, 12); d.mw = 1; d.rs2u = 1; end
            7'h13: begin d.imm = sext(i >> 20, 12); d.rw = 1; end
            7'h33: begin d.imm = 0; d.rw = 1; d.rs2u = 1; end
            7'h0F, 7'h73: d.known = 0;
            default: begin d.known = 0; d.ill = 1; end
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_we && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    task automatic model_reset();
        m_ifv = 0; m_ifpc = 0; m_ifins = 32'h13; m_ex = '0;
        for (int k = 0; k < 32; k++) rf[k] = 0;
    endtask

    task automatic check_ex();
        c = ctrl_t'(idex_ctrl);
        chk("valid", {31'd0, idex_valid}, {31'd0, m_ex.v});
        if (m_ex.v) begin
            chk("pc", idex_pc, m_ex.pc);
            chk("rd", {27'd0, idex_rd}, {27'd0, m_ex.rd});
            chk("rs1", {27'd0, idex_rs1}, {27'd0, m_ex.rs1});
            chk("rs2", {27'd0, idex_rs2}, {27'd0, m_ex.rs2});
            chk("rs1_data", idex_rs1_data, m_ex.rs1d);
            chk("rs2_data", idex_rs2_data, m_ex.rs2d);
            if (m_ex.d.known) chk("imm", idex_imm, m_ex.d.imm);
            chk("ctrl", {22'd0, c.mem_read, c.mem_write, c.reg_write, c.branch, c.jump,
                         c.jalr, c.illegal, c.wb_sel, 1'b0},
                        {22'd0, m_ex.d.mr, m_ex.d.mw, m_ex.d.rw, m_ex.d.br, m_ex.d.jp,
                         m_ex.d.jr, m_ex.d.ill, m_ex.d.wb, 1'b0});
        end else begin
            chk("bubble_ctrl", {14'd0, idex_ctrl}, 32'd0);
            chk("bubble_rd", {27'd0, idex_rd}, 32'd0);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [31:0] pc, input logic [31:0] ins,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        dec_t d;
        logic es;
        ex_t nx;
        @(negedge clk);
        rst = r; flush = f; pc_if = pc; instr_if = ins;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        d  = ref_dec(m_ifins);
        es = !f && m_ifv && m_ex.v && m_ex.d.mr && m_ex.rd != 0 &&
             ((d.rs1u && m_ifins[19:15] == m_ex.rd) || (d.rs2u && m_ifins[24:20] == m_ex.rd));
        last_stall = stall;
        chk("stall", {31'd0, stall}, {31'd0, es});
        if (r) begin
            model_reset();
        end else begin
            nx.v = m_ifv; nx.pc = m_ifpc;
            nx.rs1 = m_ifins[19:15]; nx.rs2 = m_ifins[24:20]; nx.rd = m_ifins[11:7];
            nx.rs1d = rd_reg(nx.rs1); nx.rs2d = rd_reg(nx.rs2);
            nx.d = m_ifv ? d : '0;
            if (f || es) begin
                nx.v = 0; nx.rd = 0; nx.d = '0;
            end
            if (f) begin
                m_ifv = 0; m_ifins = 32'h13;
            end else if (!es) begin
                m_ifv = 1; m_ifpc = pc; m_ifins = ins;
            end
            m_ex = nx;
            if (we && wrd != 0) rf[wrd] = wd;
        end
        @(posedge clk);
        #1;
        check_ex();
    endtask

    task automatic run(input logic [31:0] pc, input logic [31:0] ins);
        step(0, 0, pc, ins, 0, 0, 0);
    endtask

    logic [6:0]  ops [12];
    logic [31:0] ri;

    initial begin
        rst = 1; flush = 0; pc_if = 0; instr_if = 32'h13; wb_we = 0; wb_rd = 0; wb_data = 0;
        model_reset();
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

        step(1, 0, 0, 32'h13, 0, 0, 0);
        step(1, 0, 0, 32'h13, 0, 0, 0);
        chk("rst_valid", {31'd0, idex_valid}, 0);
        chk("rst_ctrl", {14'd0, idex_ctrl}, 0);
        chk("rst_pc", idex_pc, 0);
        #1 chk("rst_stall", {31'd0, stall}, 0);

        // addi x1,x0,5
        run(0, 32'h0050_0093);
        run(4, 32'h13);
        c = ctrl_t'(idex_ctrl);
        chk("addi_valid", {31'd0, idex_valid}, 1);
        chk("addi_pc", idex_pc, 0);
        chk("addi_rd", {27'd0, idex_rd}, 1);
        chk("addi_imm", idex_imm, 5);
        chk("addi_ctl", {27'd0, c.reg_write, c.alu_src_imm, c.alu_op}, {27'd0, 1'b1, 1'b1, 4'd0});

        // every register reads back as zero after reset
        for (int i = 0; i < 32; i++) begin
            ri = 32'h33; ri[19:15] = i[4:0]; ri[24:20] = i[4:0];
            run(32'h10 + 4 * i, ri);
        end

        run(32'h400, 32'hFE00_0CE3);
        run(32'h404, 32'h13);
        c = ctrl_t'(idex_ctrl);
        chk("beq_imm", idex_imm, 32'hFFFF_FFF8);
        chk("beq_ctl", {30'd0, c.branch, c.reg_write}, {30'd0, 1'b1, 1'b0});

        run(32'h500, 32'h0010_8133);
        step(0, 0, 32'h504, 32'h13, 1, 1, 32'hDEAD_BEEF);
        chk("byp_rs1", idex_rs1_data, 32'hDEAD_BEEF);
        chk("byp_rs2", idex_rs2_data, 32'hDEAD_BEEF);
        step(0, 0, 32'h508, 32'h13, 1, 0, 32'hFFFF_FFFF);
        run(32'h50C, 32'h0000_0133);
        run(32'h510, 32'h13);
        chk("x0_read", idex_rs1_data, 0);

        run(32'h100, 32'h0000_2283);
        run(32'h104, 32'h0002_8333);
        run(32'h108, 32'h13);
        chk("lu_stall", {31'd0, last_stall}, 1);
        chk("lu_bubble", {31'd0, idex_valid}, 0);
        run(32'h108, 32'h13);
        chk("lu_stall_once", {31'd0, last_stall}, 0);
        chk("lu_issue_v", {31'd0, idex_valid}, 1);
        chk("lu_issue_pc", idex_pc, 32'h104);

        run(32'h200, 32'h0000_2283);
        run(32'h204, 32'h0002_8333);
        step(0, 1, 32'h208, 32'h13, 0, 0, 0);
        chk("fl_stall", {31'd0, last_stall}, 0);
        chk("fl_idex_v", {31'd0, idex_valid}, 0);
        chk("fl_ifid_v", {31'd0, dut.ifid_valid}, 0);

        run(32'h300, 32'h0000_2283);
        run(32'h304, 32'h0002_8333);
        step(1, 0, 32'h308, 32'h13, 0, 0, 0);
        chk("rs_idex_v", {31'd0, idex_valid}, 0);
        chk("rs_stall", {31'd0, stall}, 0);

        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 11)];
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            step(0, ($urandom_range(0, 15) == 0), $urandom & ~32'd3, ri,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the in-order 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its PC and instruction. It owns the IF/ID and ID/EX pipeline registers, the 32x32 register file with WB write-through bypass, the immediate generator and control decode, and load-use hazard detection. Its stall output drives the fetch stage's stall input.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into the IF/ID and ID/EX PC fields on reset or bubble
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset or flush (addi x0,x0,0)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
pc_if  in  32  PC of the instruction presented by fetch
instr_if  in  32  instruction word from fetch
flush  in  1  branch/jump redirect from EX; squashes IF/ID and ID/EX
wb_we  in  1  writeback register-write enable
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
stall  out  1  load-use stall request to fetch (hold PC)
idex_valid  out  1  ID/EX entry is a real instruction
idex_pc  out  32  PC of the ID/EX instruction
idex_rs1_data  out  32  rs1 operand
idex_rs2_data  out  32  rs2 operand
idex_imm  out  32  sign-extended immediate
idex_rs1  out  5  rs1 index (for EX forwarding)
idex_rs2  out  5  rs2 index
idex_rd  out  5  destination index
idex_ctrl  out  CTRL_W (18)  packed ctrl_t: alu_op[4], alu_src_imm, alu_src_pc, mem_read, mem_write, reg_write, wb_sel[2] (0 alu / 1 mem / 2 pc+4), branch, jump, jalr, illegal, funct3[3]

Behaviour:
- Reset (sync, rst=1 at posedge): ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=RESET_PC. idex_valid=0, idex_ctrl=0, all idex data fields 0, idex_pc=RESET_PC. All 32 registers are cleared to 0. stall=0 while either pipeline register is invalid.
- IF/ID register, priority rst > flush > stall > load:
  - flush: valid=0, instr=NOP_INSTR.
  - stall: hold all fields.
  - otherwise: capture pc_if and instr_if, set valid=1.
- ID/EX register, priority rst > flush > stall > load:
  - flush or stall: insert a bubble (valid=0, ctrl=0, rd=0).
  - otherwise: load the decoded IF/ID contents. valid=ifid_valid; ctrl is forced to 0 if ifid_valid=0.
- Latency: an instruction captured at edge N appears on the idex_* outputs after edge N+1.
- Load-use stall (combinational from registered state): stall = !flush && ifid_valid && idex_valid && idex_ctrl.mem_read && idex_rd!=0 && ((rs1_used && rs1==idex_rd) || (rs2_used && rs2==idex_rd)).
  - rs1_used: every opcode except LUI, AUIPC, JAL.
  - rs2_used: R-type, STORE, BRANCH.
  - A stall lasts exactly one cycle per load-use pair.
- Register file: 2 async read ports, 1 write port.
  - Write at posedge when wb_we && wb_rd!=0.
  - x0 always reads 0.
  - Read bypass: when wb_we && wb_rd==rsX && rsX!=0, the read returns wb_data in the same cycle.
- Immediates (32-bit, sign bit = instr[31]):
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit 0 = 0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit 0 = 0.
  - R-type: imm = 0.
- Control decode covers all RV32I opcodes.
  - Unknown opcode: ctrl=0 except illegal=1. valid still propagates; the trap is handled downstream.
  - FENCE and SYSTEM decode as NOPs.
- Simultaneous flush and stall: flush wins. Both registers bubble and stall=0.
- Reset asserted mid-stall: the registers clear at that edge and stall drops.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams.
  - NOP_INSTR.
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
  - wb_sel_e.
  - ctrl_t packed struct and CTRL_W.
- One sub-module: regfile_2r1w (32x32, sync reset, x0 hardwired, write-through bypass).
- Decode and imm-gen remain combinational always blocks inside id_stage.

Test Plan:
- Reset: hold rst for 2 cycles, release -> idex_valid=0, idex_ctrl=0, stall=0. Reading every register through decode returns 0.
- Decode: instr_if=0x00500093 at pc 0 -> two edges later idex_valid=1, idex_pc=0, idex_rd=1, idex_imm=5, reg_write=1, alu_src_imm=1, alu_op=ADD.
- B-imm: instr_if=0xFE000CE3 (beq x0,x0,-8) -> idex_imm=0xFFFFFFF8, branch=1, reg_write=0.
- Bypass and x0:
  - wb_we=1, wb_rd=1, wb_data=0xDEADBEEF in the same cycle that IF/ID holds add x2,x1,x1 -> idex_rs1_data=idex_rs2_data=0xDEADBEEF.
  - wb_rd=0, wb_data=0xFFFFFFFF -> a later read of x0 returns 0.
- Load-use: 0x00002283 (lw x5,0(x0)) then 0x00028333 (add x6,x5,x0) -> stall=1 for exactly one cycle, one bubble in ID/EX, the add issues the following cycle with its PC unchanged.
- Flush during stall: create the load-use case and assert flush in the stall cycle -> stall=0, and idex_valid=0 and ifid_valid=0 after the edge.
